// File: rtl/lsq_regress_ctrl_if.sv
// +------------------------------------------------------------------+
// | lsq_regress_ctrl_if : request, sample-RAM, accumulator and       |
// | inverse-unit signals of the regression sequencer.  Rev 1.0       |
// +------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

interface lsq_regress_ctrl_if #(
  parameter int AW = 8,
  parameter int DW = 16
);
  logic          req;
  logic          abort;
  logic          busy;
  logic          done;
  logic          err;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_x;
  logic [DW-1:0] mem_y;
  logic          blk_clr_n;
  logic          acc_start;
  logic [DW-1:0] acc_xi;
  logic [DW-1:0] acc_yi;
  logic          xtx_valid;
  logic          xty_valid;
  logic          inv_start;

  modport master (
    input  req, abort, mem_x, mem_y, xtx_valid, xty_valid,
    output busy, done, err, mem_rd, mem_addr, blk_clr_n,
           acc_start, acc_xi, acc_yi, inv_start
  );

  modport slave (
    output req, abort, mem_x, mem_y, xtx_valid, xty_valid,
    input  busy, done, err, mem_rd, mem_addr, blk_clr_n,
           acc_start, acc_xi, acc_yi, inv_start
  );
endinterface

`default_nettype wire

// File: rtl/lsq_regress_ctrl.sv
// +------------------------------------------------------------------+
// | lsq_regress_ctrl : sequencer for one least-squares regression    |
// | pass (stream, accumulate, invert).  Rev 1.0                      |
// +------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module lsq_regress_ctrl #(
  parameter int N       = 256,
  parameter int AW      = 8,
  parameter int DW      = 16,
  parameter int INV_LAT = 8,
  parameter int ACC_TO  = 1023
) (
  input  logic                 clk,
  input  logic                 rst_n,
  lsq_regress_ctrl_if.master   bus
);

  // One counter serves both the WAIT_ACC timeout and the INV latency.
  localparam int TMAX = (ACC_TO > INV_LAT) ? ACC_TO : INV_LAT;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [AW:0]   ADDR_LAST = (AW+1)'(N - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(ACC_TO);
  localparam logic [TW-1:0] TO_WARN   = TW'(ACC_TO - 1);
  localparam logic [TW-1:0] INV_LAST  = TW'(INV_LAT - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLEAR    = 3'd1,
    LAUNCH   = 3'd2,
    STREAM   = 3'd3,
    WAIT_ACC = 3'd4,
    INV      = 3'd5,
    DONE     = 3'd6
  } state_t;

  state_t        state, state_d;
  logic [AW:0]   addr_cnt, addr_d;
  logic [TW-1:0] tcnt, tcnt_d;
  logic          stream_vld;
  logic          busy_q, done_q, err_q, mem_rd_q, acc_start_q, inv_start_q, blk_clr_n_q;
  logic          busy_d, done_d, err_d, mem_rd_d, acc_start_d, inv_start_d, blk_clr_n_d;
  logic          abort_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      addr_cnt    <= '0;
      tcnt        <= '0;
      stream_vld  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_rd_q    <= 1'b0;
      acc_start_q <= 1'b0;
      inv_start_q <= 1'b0;
      blk_clr_n_q <= 1'b1;
    end else begin
      state       <= state_d;
      addr_cnt    <= addr_d;
      tcnt        <= tcnt_d;
      stream_vld  <= mem_rd_q;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      mem_rd_q    <= mem_rd_d;
      acc_start_q <= acc_start_d;
      inv_start_q <= inv_start_d;
      blk_clr_n_q <= blk_clr_n_d;
    end
  end

  always_comb begin
    state_d   = state;
    addr_d    = addr_cnt;
    tcnt_d    = tcnt;
    err_d     = 1'b0;
    abort_hit = 1'b0;

    case (state)
      IDLE: begin
        if (bus.req) state_d = CLEAR;
      end
      CLEAR: begin
        state_d = LAUNCH;
        addr_d  = '0;
        tcnt_d  = '0;
      end
      LAUNCH: begin
        state_d = STREAM;
        addr_d  = addr_cnt + 1'b1;
      end
      STREAM: begin
        if (addr_cnt == ADDR_LAST) state_d = WAIT_ACC;
        else                       addr_d  = addr_cnt + 1'b1;
      end
      WAIT_ACC: begin
        // err is registered, so it is raised one count early to coincide
        // with the last WAIT_ACC cycle.
        if (tcnt == TO_LAST) begin
          state_d = IDLE;
        end else if (bus.xtx_valid && bus.xty_valid) begin
          state_d = INV;
          tcnt_d  = '0;
        end else begin
          tcnt_d = tcnt + 1'b1;
          err_d  = (tcnt == TO_WARN);
        end
      end
      INV: begin
        if (tcnt == INV_LAST) state_d = DONE;
        else                  tcnt_d  = tcnt + 1'b1;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state != IDLE && bus.abort) begin
      state_d   = IDLE;
      abort_hit = 1'b1;
      err_d     = 1'b0;
    end

    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    mem_rd_d    = (state_d == LAUNCH) || (state_d == STREAM);
    acc_start_d = (state_d == LAUNCH);
    blk_clr_n_d = !((state_d == CLEAR) || abort_hit);

    // inv_start holds across IDLE so the inverse outputs stay valid.
    if ((state_d == INV) || (state_d == DONE))         inv_start_d = 1'b1;
    else if ((state_d == CLEAR) || abort_hit)          inv_start_d = 1'b0;
    else                                               inv_start_d = inv_start_q;
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.mem_rd    = mem_rd_q;
  assign bus.mem_addr  = addr_cnt[AW-1:0];
  assign bus.blk_clr_n = blk_clr_n_q;
  assign bus.acc_start = acc_start_q;
  assign bus.inv_start = inv_start_q;
  assign bus.acc_xi    = stream_vld ? bus.mem_x : {DW{1'b0}};
  assign bus.acc_yi    = stream_vld ? bus.mem_y : {DW{1'b0}};

endmodule

`default_nettype wire

// File: tb/tb_lsq_regress_ctrl.sv
// +------------------------------------------------------------------+
// | tb_lsq_regress_ctrl : directed bench with RAM and accumulator    |
// | models for lsq_regress_ctrl.  Rev 1.0                            |
// +------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_lsq_regress_ctrl;

  localparam int N       = 256;
  localparam int AW      = 8;
  localparam int DW      = 16;
  localparam int INV_LAT = 8;
  localparam int ACC_TO  = 1023;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  lsq_regress_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  lsq_regress_ctrl #(
    .N(N), .AW(AW), .DW(DW), .INV_LAT(INV_LAT), .ACC_TO(ACC_TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Registered sample RAM: x = i, y = 2i
  logic [DW-1:0] ram_x = '0;
  logic [DW-1:0] ram_y = '0;
  always @(posedge clk) begin
    if (bus.mem_rd) begin
      ram_x <= DW'(bus.mem_addr);
      ram_y <= DW'({bus.mem_addr, 1'b0});
    end
  end
  assign bus.mem_x = ram_x;
  assign bus.mem_y = ram_y;

  // Accumulators: no self-reset between runs, only the clear wipes them.
  logic [31:0] sum_x    = '0;
  logic [31:0] sum_y    = '0;
  int          acc_cnt  = 0;
  logic        acc_run  = 1'b0;
  logic        acc_vld  = 1'b0;
  logic        hold_xty = 1'b0;
  always @(posedge clk) begin
    if (!(bus.blk_clr_n && rst_n)) begin
      sum_x <= '0; sum_y <= '0; acc_cnt <= 0; acc_run <= 1'b0; acc_vld <= 1'b0;
    end else if (bus.acc_start) begin
      acc_cnt <= 0; acc_run <= 1'b1;
    end else if (acc_run) begin
      if (acc_cnt < N) begin
        sum_x <= sum_x + 32'(bus.acc_xi);
        sum_y <= sum_y + 32'(bus.acc_yi);
      end
      acc_cnt <= acc_cnt + 1;
      if (acc_cnt + 1 == N + 2) begin
        acc_vld <= 1'b1;
        acc_run <= 1'b0;
      end
    end
  end
  assign bus.xtx_valid = acc_vld;
  assign bus.xty_valid = acc_vld & ~hold_xty;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Full run from the current IDLE cycle (cycle 0) through cycle 271.
  task automatic run_nominal(input string tag, input bit hold_req);
    int bad_busy = 0, bad_rd = 0, bad_addr = 0, bad_dat = 0, bad_ctl = 0, bad_inv = 0;
    int done_cyc = -1;
    logic e_busy, e_rd, e_inv;
    logic [31:0] e_xi;
    bus.req = 1'b1;
    for (int c = 1; c <= 271; c++) begin
      tick();
      if (!hold_req) bus.req = 1'b0;
      e_busy = (c >= 1) && (c <= 270);
      e_rd   = (c >= 2) && (c <= 257);
      e_inv  = (c >= 262);
      e_xi   = (c >= 3 && c <= 258) ? 32'(c - 3) : 32'd0;
      if (bus.busy !== e_busy) bad_busy++;
      if (bus.mem_rd !== e_rd) bad_rd++;
      if (e_rd && (32'(bus.mem_addr) != 32'(c - 2))) bad_addr++;
      if (32'(bus.acc_xi) !== e_xi || 32'(bus.acc_yi) !== 2 * e_xi) bad_dat++;
      if (bus.blk_clr_n !== (c != 1) || bus.acc_start !== (c == 2) || bus.err !== 1'b0) bad_ctl++;
      if (bus.inv_start !== e_inv) bad_inv++;
      if (bus.done === 1'b1 && done_cyc < 0) done_cyc = c;
      if (bus.done === 1'b1 && c != 270) bad_ctl++;
    end
    check_eq({tag, "_busy"},     bad_busy, 0);
    check_eq({tag, "_mem_rd"},   bad_rd,   0);
    check_eq({tag, "_mem_addr"}, bad_addr, 0);
    check_eq({tag, "_acc_data"}, bad_dat,  0);
    check_eq({tag, "_ctl"},      bad_ctl,  0);
    check_eq({tag, "_inv"},      bad_inv,  0);
    check_eq({tag, "_done_cyc"}, done_cyc, 270);
    check_eq({tag, "_sum_x"},    sum_x,    32'd32640);
    check_eq({tag, "_sum_y"},    sum_y,    32'd65280);
  endtask

  initial begin
    int err_cyc, err_n, done_n, busy_at_err, busy_after, pulses, busy_seen;
    bit found;

    bus.req   = 1'b0;
    bus.abort = 1'b0;
    repeat (3) tick();
    check_eq("rst_flags", {bus.busy, bus.done, bus.err, bus.mem_rd, bus.acc_start, bus.inv_start}, 0);
    check_eq("rst_addr", bus.mem_addr, 0);
    check_eq("rst_blk_clr_n", bus.blk_clr_n, 1);
    #2 rst_n = 1'b1;
    tick(); tick();
    check_eq("idle_busy", bus.busy, 0);

    run_nominal("nom", 1'b0);
    check_eq("b2b_inv_hold", bus.inv_start, 1);
    run_nominal("b2b", 1'b0);
    run_nominal("held", 1'b1);
    tick();
    check_eq("held_reclear", {bus.busy, bus.blk_clr_n, bus.inv_start}, 3'b100);
    bus.req   = 1'b0;
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check_eq("held_abort_idle", bus.busy, 0);
    tick();

    // Timeout: X'Y never reports valid
    hold_xty    = 1'b1;
    err_cyc     = -1;
    err_n       = 0;
    done_n      = 0;
    busy_at_err = 0;
    busy_after  = 1;
    bus.req     = 1'b1;
    for (int c = 1; c <= 1290; c++) begin
      tick();
      bus.req = 1'b0;
      if (bus.err === 1'b1) begin
        err_n++;
        if (err_cyc < 0) begin
          err_cyc     = c;
          busy_at_err = int'(bus.busy);
        end
      end
      if (err_cyc >= 0 && c == err_cyc + 1) busy_after = int'(bus.busy);
      if (bus.done === 1'b1) done_n++;
    end
    hold_xty = 1'b0;
    check_eq("to_err_cyc",   err_cyc,     1281);
    check_eq("to_err_count", err_n,       1);
    check_eq("to_no_done",   done_n,      0);
    check_eq("to_busy_err",  busy_at_err, 1);
    check_eq("to_busy_after", busy_after, 0);
    check_eq("to_inv_low",   bus.inv_start, 0);

    // Abort in STREAM at address 100
    bus.req = 1'b1;
    tick();
    bus.req = 1'b0;
    found   = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      if (bus.mem_rd === 1'b1 && bus.mem_addr == 8'd100) found = 1'b1;
      else tick();
    end
    check_eq("abort_found", found, 1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check_eq("abort_idle", {bus.busy, bus.mem_rd, bus.blk_clr_n, bus.acc_start}, 0);
    tick();
    check_eq("abort_clr_release", bus.blk_clr_n, 1);
    pulses = 0;
    repeat (300) begin
      tick();
      if (bus.done === 1'b1 || bus.err === 1'b1) pulses++;
    end
    check_eq("abort_no_pulse", pulses, 0);
    run_nominal("post_abort", 1'b0);

    // Asynchronous reset mid-stream, no clock edge before the check
    bus.req = 1'b1;
    tick();
    bus.req = 1'b0;
    repeat (149) tick();
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_outputs",
             {bus.busy, bus.done, bus.err, bus.mem_rd, bus.acc_start, bus.inv_start, bus.blk_clr_n, bus.mem_addr},
             {7'b0000001, 8'd0});
    tick(); tick();
    #2 rst_n = 1'b1;
    pulses    = 0;
    busy_seen = 0;
    repeat (300) begin
      tick();
      if (bus.done === 1'b1 || bus.err === 1'b1) pulses++;
      if (bus.busy === 1'b1) busy_seen++;
    end
    check_eq("arst_no_pulse", pulses, 0);
    check_eq("arst_stay_idle", busy_seen, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
